// File: rtl/aquarium_pkg.sv
// Shared constants for the aquarium mode sequencer: state codes, mux selects, fault bit indices.
package aquarium_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_COUNT = 3'd2;
  localparam state_t ST_CLEAN = 3'd3;
  localparam state_t ST_TEMP  = 3'd4;
  localparam state_t ST_FOOD  = 3'd5;
  localparam state_t ST_SALT  = 3'd6;
  localparam state_t ST_ERROR = 3'd7;

  localparam logic [4:0] SEL_NONE  = 5'b00000;
  localparam logic [4:0] SEL_COUNT = 5'b00001;
  localparam logic [4:0] SEL_CLEAN = 5'b00010;
  localparam logic [4:0] SEL_TEMP  = 5'b00100;
  localparam logic [4:0] SEL_FOOD  = 5'b01000;
  localparam logic [4:0] SEL_SALT  = 5'b10000;
  localparam logic [4:0] SEL_ERROR = 5'b11111;

  localparam int unsigned FAULT_CLEAN = 0;
  localparam int unsigned FAULT_TEMP  = 1;
  localparam int unsigned FAULT_FOOD  = 2;
  localparam int unsigned FAULT_SALT  = 3;

  function automatic logic [4:0] sel_of(state_t st);
    logic [4:0] sel;
    sel = SEL_NONE;
    case (st)
      ST_COUNT: sel = SEL_COUNT;
      ST_CLEAN: sel = SEL_CLEAN;
      ST_TEMP:  sel = SEL_TEMP;
      ST_FOOD:  sel = SEL_FOOD;
      ST_SALT:  sel = SEL_SALT;
      ST_ERROR: sel = SEL_ERROR;
      default:  sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/aq_dwell_timer.sv
// Loadable down-counter; done is high on the last cycle of a DWELL-cycle dwell.
module aq_dwell_timer #(
  parameter int unsigned DWELL = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int unsigned TW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [TW-1:0] cnt_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= TW'(DWELL - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/aquarium_mode_sequencer.sv
// Loads the four sensor registers, then steps the display mux through each mode,
// dropping into error mode on the first out-of-limit sensor.
module aquarium_mode_sequencer
  import aquarium_pkg::*;
#(
  parameter int unsigned        DWELL     = 4,
  parameter int unsigned        CNT_W     = 8,
  parameter logic [DATA_W-1:0]  CLEAN_MIN = 8'd10,
  parameter logic [DATA_W-1:0]  TEMP_MIN  = 8'd20,
  parameter logic [DATA_W-1:0]  TEMP_MAX  = 8'd30,
  parameter logic [DATA_W-1:0]  FOOD_MIN  = 8'd5,
  parameter logic [DATA_W-1:0]  SALT_MAX  = 8'd200
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              run,
  input  logic              err_clear,
  input  logic [DATA_W-1:0] q_clean,
  input  logic [DATA_W-1:0] q_temp,
  input  logic [DATA_W-1:0] q_food,
  input  logic [DATA_W-1:0] q_salt,
  output logic [3:0]        load_en,
  output logic [4:0]        select,
  output logic [CNT_W-1:0]  round_count,
  output logic [3:0]        fault,
  output logic              busy
);

  state_t           state_q, state_d;
  logic [3:0]       fault_q, fault_d;
  logic [3:0]       load_en_q;
  logic [4:0]       select_q;
  logic [CNT_W-1:0] count_q;
  logic             busy_q;
  logic             dwell_done, dwell_load;
  logic             pass_clean, pass_temp, pass_food, pass_salt;

  assign pass_clean = (q_clean >= CLEAN_MIN);
  assign pass_temp  = (q_temp >= TEMP_MIN) && (q_temp <= TEMP_MAX);
  assign pass_food  = (q_food >= FOOD_MIN);
  assign pass_salt  = (q_salt <= SALT_MAX);

  // Reload the dwell counter on every state change so each mode starts a fresh dwell.
  assign dwell_load = (state_d != state_q);

  aq_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .CLK   (CLK),
    .reset (reset),
    .load  (dwell_load),
    .done  (dwell_done)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_COUNT;
      ST_COUNT: if (dwell_done) state_d = ST_CLEAN;
      ST_CLEAN: if (dwell_done) begin
        if (pass_clean) begin
          state_d = ST_TEMP;
        end else begin
          state_d = ST_ERROR;
          fault_d[FAULT_CLEAN] = 1'b1;
        end
      end
      ST_TEMP: if (dwell_done) begin
        if (pass_temp) begin
          state_d = ST_FOOD;
        end else begin
          state_d = ST_ERROR;
          fault_d[FAULT_TEMP] = 1'b1;
        end
      end
      ST_FOOD: if (dwell_done) begin
        if (pass_food) begin
          state_d = ST_SALT;
        end else begin
          state_d = ST_ERROR;
          fault_d[FAULT_FOOD] = 1'b1;
        end
      end
      ST_SALT: if (dwell_done) begin
        if (pass_salt) begin
          state_d = run ? ST_LOAD : ST_IDLE;
        end else begin
          state_d = ST_ERROR;
          fault_d[FAULT_SALT] = 1'b1;
        end
      end
      ST_ERROR: if (err_clear) begin
        state_d = ST_IDLE;
        fault_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fault_q   <= '0;
      load_en_q <= '0;
      select_q  <= SEL_NONE;
      count_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      load_en_q <= (state_d == ST_LOAD) ? 4'b1111 : 4'b0000;
      select_q  <= sel_of(state_d);
      busy_q    <= (state_d != ST_IDLE) && (state_d != ST_ERROR);
      if (state_d == ST_LOAD) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign load_en     = load_en_q;
  assign select      = select_q;
  assign round_count = count_q;
  assign fault       = fault_q;
  assign busy        = busy_q;

endmodule
